muldiv_hilo_unit: RTL and testbench
===================================

MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-002 The block SHALL have the port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port alucontrol, input, 8 bits: EX-stage operation code; only EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MFHI_OP and EXE_MFLO_OP (defines2.vh) are acted on; all other codes are no-ops.
REQ-004 The block SHALL have the port valid_i, input, 1 bit: the EX-stage instruction is live.
REQ-005 The block SHALL have the port stall_i, input, 1 bit: the pipeline is held by another source.
REQ-006 The block SHALL have the port flush_i, input, 1 bit: exception/ERET kill of the EX stage.
REQ-007 The block SHALL have the ports src_a and src_b, input, 32 bits each: rs and rt operands.
REQ-008 The block SHALL have the port busy_o, output, 1 bit: stall request to the hazard unit.
REQ-009 The block SHALL have the ports hi_o and lo_o, output, 32 bits each: architectural HI and LO, driven combinationally from registers.
REQ-010 The block SHALL have the port result_o, output, 32 bits: hi_o for MFHI, lo_o for MFLO, 0 otherwise; combinational.

Function
REQ-011 The block SHALL define issue as valid_i=1 and flush_i=0 with the FSM in IDLE.
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 On issue of MTHI or MTLO, the block SHALL write HI or LO with src_a at the cycle-end edge.
REQ-014 On issue of MULT or MULTU, the block SHALL write the signed or unsigned 64-bit product {HI,LO} at the cycle-end edge (1-cycle latency); busy_o SHALL stay 0.
REQ-015 On issue of DIV or DIVU, the block SHALL latch the operand magnitudes, the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a; signed only), clear the iteration counter, and enter RUN.
REQ-016 In RUN, the block SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder for exactly 32 cycles; after the 32nd step it SHALL apply the sign fix-up, write HI=remainder and LO=quotient, and enter DONE.
REQ-017 busy_o SHALL be 1 in the DIV/DIVU issue cycle and in every RUN cycle (33 cycles total), and SHALL be 0 in IDLE (except for a DIV/DIVU issue) and in DONE.
REQ-018 DONE SHALL ignore valid_i, because the same divide is still in EX; it SHALL return to IDLE on the first edge with stall_i=0.
REQ-019 A divide by zero SHALL raise no exception, SHALL take the same 33 cycles, and SHALL write HI=src_a and LO=32'hFFFFFFFF with no sign fix-up.
REQ-020 DIV 32'h80000000 / 32'hFFFFFFFF SHALL yield LO=32'h80000000 and HI=0 (wrap, no trap).
REQ-021 flush_i=1 in any state SHALL return the FSM to IDLE at the edge, abort any divide without writing HI/LO, suppress any same-cycle MT*/MULT* write, and force busy_o=0 combinationally.
REQ-022 Operations other than those listed in REQ-003 SHALL never modify HI or LO.

Reset
REQ-023 While resetn=0 at a rising edge, the block SHALL set HI=0, LO=0, the FSM to IDLE and the counter to 0; consequently busy_o=0.
REQ-024 A reset during RUN or DONE SHALL discard the divide, with no HI/LO write.

Verification
REQ-025 MULT src_a=32'hFFFFFFFE, src_b=3 -> the next cycle shows hi_o=32'hFFFFFFFF and lo_o=32'hFFFFFFFA, and busy_o never rises; MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi_o=32'hFFFFFFFE, lo_o=1.
REQ-026 DIV -7/2 (32'hFFFFFFF9, 2) -> busy_o high for exactly 33 cycles, then lo_o=32'hFFFFFFFD and hi_o=32'hFFFFFFFF; DIVU 100/7 -> lo_o=14, hi_o=2.
REQ-027 DIVU 32'h64/0 -> after 33 cycles, hi_o=32'h64 and lo_o=32'hFFFFFFFF; DIV 32'h80000000/32'hFFFFFFFF -> lo_o=32'h80000000, hi_o=0.
REQ-028 Preload HI=32'hAAAA0000 and LO=32'h5555 via MTHI/MTLO, start a DIV, then assert flush_i in RUN cycle 10 -> busy_o drops that cycle, hi_o and lo_o are unchanged, and a DIVU issued the next cycle completes correctly.
REQ-029 Hold stall_i=1 for 3 cycles after a divide completes, with valid_i held -> the FSM stays in DONE, there is no second divide, and busy_o=0; back-to-back DIVs after release each take 33 busy cycles.
REQ-030 Assert resetn=0 in RUN cycle 20 -> hi_o=lo_o=0, busy_o=0 and IDLE on the next cycle; MFHI then gives result_o=0.

Source files
------------

// File: rtl/muldiv_hilo_unit.sv
// HI/LO register file with a 1-cycle multiplier and a 32-step
// restoring divider for the EX stage of a MIPS-style pipeline.
module muldiv_hilo_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  alucontrol,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] result_o
);

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        issue;
  logic        is_div;
  logic        div_signed;
  logic        div_zero;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        step_ok;
  logic [31:0] rem_nx;
  logic [31:0] quot_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        last_step;

  assign issue      = valid_i & ~flush_i & (state == IDLE);
  assign div_signed = (alucontrol == EXE_DIV_OP);
  assign is_div     = div_signed | (alucontrol == EXE_DIVU_OP);
  assign div_zero   = (src_b == 32'd0);

  // A zero divisor keeps the raw dividend so the remainder comes out as src_a.
  assign a_neg = div_signed & ~div_zero & src_a[31];
  assign b_neg = div_signed & src_b[31];
  assign a_mag = a_neg ? 32'd0 - src_a : src_a;
  assign b_mag = b_neg ? 32'd0 - src_b : src_b;

  // Sign-extending both operands lets one 64-bit multiply serve both forms.
  assign mul_signed = (alucontrol == EXE_MULT_OP);
  assign mul_a      = {{32{mul_signed & src_a[31]}}, src_a};
  assign mul_b      = {{32{mul_signed & src_b[31]}}, src_b};
  assign product    = mul_a * mul_b;

  assign rem_sh  = {rem, quot[31]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign step_ok = ~diff[32];
  assign rem_nx  = step_ok ? diff[31:0] : rem_sh[31:0];
  assign quot_nx = {quot[30:0], step_ok};
  assign q_fin   = q_neg ? 32'd0 - quot_nx : quot_nx;
  assign r_fin   = r_neg ? 32'd0 - rem_nx : rem_nx;

  assign last_step = (state == RUN) & (cnt == 5'd31);

  assign busy_o = ~flush_i &
    (((state == IDLE) & valid_i & is_div) | (state == RUN));

  assign hi_o = hi;
  assign lo_o = lo;

  // Move-from ops read HI/LO straight out of the registers.
  always_comb begin
    result_o = 32'd0;
    case (alucontrol)
      EXE_MFHI_OP: result_o = hi;
      EXE_MFLO_OP: result_o = lo;
      default:     result_o = 32'd0;
    endcase
  end

  // Divider sequencer: latch operands on issue, one step per RUN cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 5'd0;
      rem   <= 32'd0;
      quot  <= 32'd0;
      dvs   <= 32'd0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i && is_div) begin
            state <= RUN;
            cnt   <= 5'd0;
            rem   <= 32'd0;
            quot  <= a_mag;
            dvs   <= b_mag;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
          end
        end
        RUN: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!stall_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // HI/LO writes: divide result, moves and products; flush blocks all.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (!flush_i) begin
      if (last_step) begin
        hi <= r_fin;
        lo <= q_fin;
      end else if (issue) begin
        case (alucontrol)
          EXE_MTHI_OP:  hi <= src_a;
          EXE_MTLO_OP:  lo <= src_a;
          EXE_MULT_OP,
          EXE_MULTU_OP: {hi, lo} <= product;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: driver pushes expectations,
// a negedge monitor pops them on busy-run ends and MFHI/MFLO reads.
module tb_muldiv_hilo_unit;

  localparam logic [7:0] MFHI  = 8'b0001_0000;
  localparam logic [7:0] MTHI  = 8'b0001_0001;
  localparam logic [7:0] MFLO  = 8'b0001_0010;
  localparam logic [7:0] MTLO  = 8'b0001_0011;
  localparam logic [7:0] MULT  = 8'b0001_1000;
  localparam logic [7:0] MULTU = 8'b0001_1001;
  localparam logic [7:0] DIV   = 8'b0001_1010;
  localparam logic [7:0] DIVU  = 8'b0001_1011;

  logic        clk;
  logic        resetn;
  logic [7:0]  alucontrol;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] result_o;

  muldiv_hilo_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .alucontrol (alucontrol),
    .valid_i    (valid_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy_o     (busy_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .result_o   (result_o)
  );

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } busy_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } rd_t;

  busy_t bq[$];
  rd_t   rq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    run     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: busy-run ends and move-from reads are the DUT responses.
  always @(negedge clk) begin
    busy_t be;
    rd_t   re;
    if (busy_o === 1'b1) begin
      run++;
    end else if (run > 0) begin
      if (bq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL busy_unexpected: got run of %0d, want none", run);
      end else begin
        be = bq.pop_front();
        chk("busy_len", 32'(run), 32'(be.len));
        chk("div_hi", hi_o, be.hi);
        chk("div_lo", lo_o, be.lo);
      end
      run = 0;
    end
    if (valid_i === 1'b1 && flush_i === 1'b0 &&
        (alucontrol == MFHI || alucontrol == MFLO)) begin
      if (rq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL read_unexpected: got read, want none");
      end else begin
        re = rq.pop_front();
        chk("rd_hi", hi_o, re.hi);
        chk("rd_lo", lo_o, re.lo);
        chk("rd_result", result_o,
            (alucontrol == MFHI) ? re.hi : re.lo);
      end
    end
  end

  task automatic op1(input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic fl);
    @(posedge clk);
    #1;
    alucontrol = op;
    valid_i    = 1'b1;
    src_a      = a;
    src_b      = b;
    flush_i    = fl;
    stall_i    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] op, input logic [31:0] eh,
                    input logic [31:0] el);
    rd_t r;
    r.hi = eh;
    r.lo = el;
    rq.push_back(r);
    op1(op, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic div(input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int hold,
                     input logic [31:0] eh, input logic [31:0] el);
    busy_t e;
    int    n;
    e.len = 33;
    e.hi  = eh;
    e.lo  = el;
    bq.push_back(e);
    op1(op, a, b, 1'b0);
    stall_i = (hold > 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 100);
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL div_timeout: got busy after %0d, want drop", n);
    end
    if (hold > 0) begin
      repeat (hold - 1) @(posedge clk);
      @(posedge clk);
      #1;
      stall_i = 1'b0;
    end
  endtask

  task automatic fdiv(input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int at,
                      input logic [31:0] eh, input logic [31:0] el);
    busy_t e;
    e.len = at;
    e.hi  = eh;
    e.lo  = el;
    bq.push_back(e);
    op1(op, a, b, 1'b0);
    repeat (at) @(posedge clk);
    #1;
    flush_i = 1'b1;
  endtask

  initial begin
    busy_t e;
    resetn     = 1'b0;
    alucontrol = 8'h00;
    valid_i    = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    src_a      = 32'd0;
    src_b      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    rd(MFHI, 32'd0, 32'd0);

    op1(MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    rd(MFLO, 32'hFFFFFFFF, 32'hFFFFFFFA);
    op1(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    rd(MFHI, 32'hFFFFFFFE, 32'h00000001);

    div(DIV, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    rd(MFLO, 32'hFFFFFFFF, 32'hFFFFFFFD);
    div(DIVU, 32'd100, 32'd7, 0, 32'd2, 32'd14);
    div(DIVU, 32'h64, 32'd0, 0, 32'h64, 32'hFFFFFFFF);
    div(DIV, 32'hFFFFFFF9, 32'd0, 0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    div(DIV, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 32'h80000000);
    rd(MFHI, 32'd0, 32'h80000000);

    op1(MTHI, 32'hAAAA0000, 32'd0, 1'b0);
    op1(MTLO, 32'h00005555, 32'd0, 1'b0);
    rd(MFHI, 32'hAAAA0000, 32'h00005555);
    op1(8'h20, 32'h11111111, 32'h22222222, 1'b0);
    op1(MTHI, 32'hDEADBEEF, 32'd0, 1'b1);
    op1(MULT, 32'd5, 32'd5, 1'b1);
    rd(MFLO, 32'hAAAA0000, 32'h00005555);

    fdiv(DIV, 32'd100, 32'd7, 10, 32'hAAAA0000, 32'h00005555);
    rd(MFHI, 32'hAAAA0000, 32'h00005555);
    fdiv(DIV, 32'd100, 32'd7, 10, 32'hAAAA0000, 32'h00005555);
    div(DIVU, 32'd100, 32'd7, 0, 32'd2, 32'd14);

    div(DIV, 32'h64, 32'hFFFFFFF9, 3, 32'd2, 32'hFFFFFFF2);
    div(DIV, 32'hFFFFFF9C, 32'd7, 0, 32'hFFFFFFFE, 32'hFFFFFFF2);
    div(DIVU, 32'hFFFFFFFF, 32'h10, 0, 32'hF, 32'h0FFFFFFF);
    rd(MFLO, 32'hF, 32'h0FFFFFFF);

    e.len = 21;
    e.hi  = 32'd0;
    e.lo  = 32'd0;
    bq.push_back(e);
    op1(DIV, 32'd100, 32'd7, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    valid_i = 1'b0;
    rd(MFHI, 32'd0, 32'd0);

    @(posedge clk);
    #1;
    valid_i    = 1'b0;
    alucontrol = 8'h00;
    repeat (3) @(posedge clk);
    chk("busy_q_empty", 32'(bq.size()), 32'd0);
    chk("rd_q_empty", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
